// File: rtl/intlv_filo_pkg.sv
// Shared types and pop widths for the interleaver FILO pair.
package intlv_filo_pkg;
   typedef enum logic [1:0] {EMPTY, FILL, SEALED} filo_state_e;

   localparam int RDA_W         = 10;
   localparam int RDB_W         = 4;
   localparam int RD1_W         = 1;
   localparam int DEFAULT_DEPTH = 128;
endpackage

// File: rtl/filo_bit_stack.sv
// One bit-serial FILO: fills bottom-up, is sealed, then drains top-down in pops of 10, 4 or 1 bits.
module filo_bit_stack
   import intlv_filo_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             wr_data,
   input  logic             wr_eof,
   input  logic             rda_en,
   input  logic             rdb_en,
   input  logic             rd1_en,
   output logic [RDA_W-1:0] rda_data,
   output logic [RDB_W-1:0] rdb_data,
   output logic [RD1_W-1:0] rd1_data,
   output logic             rdy4rd,
   output logic [CNT_W-1:0] cnt,
   output filo_state_e      state,
   output logic             seal,
   output logic             err
);
   localparam int AW = $clog2(DEPTH);

   filo_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RDA_W-1:0] rda_q, rda_d;
   logic [RDB_W-1:0] rdb_q, rdb_d;
   logic [RD1_W-1:0] rd1_q, rd1_d;
   logic             err_q, err_d;
   logic             mem_q [DEPTH];
   logic             mem_we;
   logic [RDA_W-1:0] pop_bits;
   int               pop_w;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rda_d    = rda_q;
      rdb_d    = rdb_q;
      rd1_d    = rd1_q;
      err_d    = 1'b0;
      mem_we   = 1'b0;
      pop_bits = '0;
      pop_w    = 0;

      if (wr_en && state_q != SEALED) begin
         if (cnt_q == CNT_W'(DEPTH)) begin
            err_d = 1'b1;
         end else begin
            mem_we  = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            state_d = FILL;
         end
      end
      // eof looks at the post-write count so a bit written with eof still seals
      if (wr_eof && state_q != SEALED && cnt_d != '0) state_d = SEALED;

      if (rda_en || rdb_en || rd1_en) begin
         if (state_q != SEALED) begin
            err_d = 1'b1;
         end else begin
            if ((rda_en && (rdb_en || rd1_en)) || (rdb_en && rd1_en)) err_d = 1'b1;
            pop_w = rda_en ? RDA_W : (rdb_en ? RDB_W : RD1_W);
            // MSB-aligned pop; positions beyond the held bits stay zero
            for (int i = 0; i < RDA_W; i++) begin
               if (i < pop_w && CNT_W'(i) < cnt_q)
                  pop_bits[RDA_W-1-i] = mem_q[AW'(cnt_q - CNT_W'(i + 1))];
            end
            if (CNT_W'(pop_w) > cnt_q) begin
               err_d = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(pop_w);
            end
            if (rda_en)      rda_d = pop_bits;
            else if (rdb_en) rdb_d = pop_bits[RDA_W-1 -: RDB_W];
            else             rd1_d = pop_bits[RDA_W-1 -: RD1_W];
            if (cnt_d == '0) state_d = EMPTY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         cnt_q   <= '0;
         rda_q   <= '0;
         rdb_q   <= '0;
         rd1_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rda_q   <= rda_d;
         rdb_q   <= rdb_d;
         rd1_q   <= rd1_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[AW'(cnt_q)] <= wr_data;
   end

   assign rda_data = rda_q;
   assign rdb_data = rdb_q;
   assign rd1_data = rd1_q;
   assign rdy4rd   = (state_q == SEALED) && (cnt_q != '0);
   assign cnt      = cnt_q;
   assign state    = state_q;
   assign seal     = (state_q != SEALED) && (state_d == SEALED);
   assign err      = err_q;
endmodule

// File: rtl/intlv_filo_pair.sv
// Ping-pong FILO pair for one interleaver partition: one side fills while the sealed side drains.
module intlv_filo_pair
   import intlv_filo_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic             wr_data,
   input  logic             wr_eof,
   output logic             wr_rdy,
   output logic             wr_err,
   input  logic             filoA_rdA_en,
   input  logic             filoB_rdA_en,
   input  logic             filoA_rdB_en,
   input  logic             filoB_rdB_en,
   input  logic             filoA_rd1_en,
   input  logic             filoB_rd1_en,
   output logic [RDA_W-1:0] filoA_rdA_data,
   output logic [RDA_W-1:0] filoB_rdA_data,
   output logic [RDB_W-1:0] filoA_rdB_data,
   output logic [RDB_W-1:0] filoB_rdB_data,
   output logic [RD1_W-1:0] filoA_rd1_data,
   output logic [RD1_W-1:0] filoB_rd1_data,
   output logic             filoA_rdy4rd,
   output logic             filoB_rdy4rd,
   output logic [CNT_W-1:0] filoA_cnt,
   output logic [CNT_W-1:0] filoB_cnt
);
   filo_state_e state_a, state_b;
   logic        seal_a, seal_b, err_a, err_b;
   logic        wr_en_a, wr_en_b, wr_eof_a, wr_eof_b;
   logic        sel_q, sel_d;        // 0 = A, 1 = B
   logic        drop_q, drop_d;

   always_comb begin
      wr_rdy   = (sel_q ? state_b : state_a) != SEALED;
      wr_en_a  = wr_en  && wr_rdy && !sel_q;
      wr_en_b  = wr_en  && wr_rdy &&  sel_q;
      wr_eof_a = wr_eof && wr_rdy && !sel_q;
      wr_eof_b = wr_eof && wr_rdy &&  sel_q;
      drop_d   = wr_en && !wr_rdy;
      sel_d    = sel_q ^ (sel_q ? seal_b : seal_a);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q  <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         sel_q  <= sel_d;
         drop_q <= drop_d;
      end
   end

   assign wr_err = drop_q | err_a | err_b;

   filo_bit_stack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_filo_a (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en_a),
      .wr_data  (wr_data),
      .wr_eof   (wr_eof_a),
      .rda_en   (filoA_rdA_en),
      .rdb_en   (filoA_rdB_en),
      .rd1_en   (filoA_rd1_en),
      .rda_data (filoA_rdA_data),
      .rdb_data (filoA_rdB_data),
      .rd1_data (filoA_rd1_data),
      .rdy4rd   (filoA_rdy4rd),
      .cnt      (filoA_cnt),
      .state    (state_a),
      .seal     (seal_a),
      .err      (err_a)
   );

   filo_bit_stack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_filo_b (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en_b),
      .wr_data  (wr_data),
      .wr_eof   (wr_eof_b),
      .rda_en   (filoB_rdA_en),
      .rdb_en   (filoB_rdB_en),
      .rd1_en   (filoB_rd1_en),
      .rda_data (filoB_rdA_data),
      .rdb_data (filoB_rdB_data),
      .rd1_data (filoB_rd1_data),
      .rdy4rd   (filoB_rdy4rd),
      .cnt      (filoB_cnt),
      .state    (state_b),
      .seal     (seal_b),
      .err      (err_b)
   );
endmodule

// File: tb/tb_intlv_filo_pair.sv
// Directed bench for intlv_filo_pair with hand-computed expectations.
module tb_intlv_filo_pair;
   logic       clk = 1'b0;
   logic       rst, wr_en, wr_data, wr_eof, wr_rdy, wr_err;
   logic       a_rda_en, b_rda_en, a_rdb_en, b_rdb_en, a_rd1_en, b_rd1_en;
   logic [9:0] a_rda, b_rda;
   logic [3:0] a_rdb, b_rdb;
   logic [0:0] a_rd1, b_rd1;
   logic       a_rdy, b_rdy;
   logic [7:0] a_cnt, b_cnt;
   int         total = 0;
   int         bad   = 0;
   logic [4:0] rev5;
   logic [2:0] bbits;

   always #5 clk = ~clk;

   intlv_filo_pair dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_eof(wr_eof),
      .wr_rdy(wr_rdy), .wr_err(wr_err),
      .filoA_rdA_en(a_rda_en), .filoB_rdA_en(b_rda_en),
      .filoA_rdB_en(a_rdb_en), .filoB_rdB_en(b_rdb_en),
      .filoA_rd1_en(a_rd1_en), .filoB_rd1_en(b_rd1_en),
      .filoA_rdA_data(a_rda), .filoB_rdA_data(b_rda),
      .filoA_rdB_data(a_rdb), .filoB_rdB_data(b_rdb),
      .filoA_rd1_data(a_rd1), .filoB_rd1_data(b_rd1),
      .filoA_rdy4rd(a_rdy), .filoB_rdy4rd(b_rdy),
      .filoA_cnt(a_cnt), .filoB_cnt(b_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      wr_en = 0; wr_data = 0; wr_eof = 0;
      a_rda_en = 0; a_rdb_en = 0; a_rd1_en = 0;
      b_rda_en = 0; b_rdb_en = 0; b_rd1_en = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic wr_bit(input logic d, input logic eof);
      wr_en = 1; wr_data = d; wr_eof = eof;
      tick();
      idle();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_wr_rdy"}, 32'(wr_rdy), 1);
      chk({tag, "_wr_err"}, 32'(wr_err), 0);
      chk({tag, "_cnts"},   {8'h0, a_cnt, 8'h0, b_cnt}, 0);
      chk({tag, "_rdy4rd"}, {a_rdy, b_rdy}, 0);
      chk({tag, "_data"},   {a_rda, b_rda, a_rdb, b_rdb, a_rd1, b_rd1}, 0);
   endtask

   initial begin
      do_reset();
      tick();
      chk_reset("rst0");

      // T1: 12 bits, eof on last; rdA then under-running rdB
      wr_bit(1,0); wr_bit(0,0); wr_bit(1,0); wr_bit(1,0);
      wr_bit(0,0); wr_bit(0,0); wr_bit(1,0); wr_bit(0,0);
      wr_bit(1,0); wr_bit(1,0); wr_bit(1,0); wr_bit(0,1);
      chk("t1_cnt12", 32'(a_cnt), 12);
      chk("t1_rdy4rd", 32'(a_rdy), 1);
      a_rda_en = 1; tick(); idle();
      chk("t1_rda_data", 32'(a_rda), 32'b0111010011);
      chk("t1_cnt2", 32'(a_cnt), 2);
      chk("t1_rda_noerr", 32'(wr_err), 0);
      a_rdb_en = 1; tick(); idle();
      chk("t1_rdb_data", 32'(a_rdb), 32'b0100);
      chk("t1_underrun_err", 32'(wr_err), 1);
      chk("t1_cnt0", 32'(a_cnt), 0);
      chk("t1_rdy4rd0", 32'(a_rdy), 0);
      tick();
      chk("t1_err_pulse", 32'(wr_err), 0);

      // T2: 5 bits into A, then write B while draining A by single pops
      do_reset();
      wr_bit(1,0); wr_bit(1,0); wr_bit(0,0); wr_bit(1,0); wr_bit(0,1);
      rev5  = 5'b01011;   // mem[4..0] read out top-first
      bbits = 3'b101;
      for (int k = 0; k < 5; k++) begin
         a_rd1_en = 1;
         if (k < 3) begin wr_en = 1; wr_data = bbits[k]; end
         tick(); idle();
         chk($sformatf("t2_rd1_%0d", k), 32'(a_rd1), 32'(rev5[4-k]));
         chk($sformatf("t2_err_%0d", k), 32'(wr_err), 0);
      end
      chk("t2_a_cnt", 32'(a_cnt), 0);
      chk("t2_b_cnt", 32'(b_cnt), 3);
      chk("t2_b_rdy4rd", 32'(b_rdy), 0);

      // T3: fill A to capacity, overflow write is dropped
      do_reset();
      for (int i = 0; i < 128; i++) wr_bit(logic'(i % 3 == 0), 0);
      chk("t3_cnt128", 32'(a_cnt), 128);
      chk("t3_noerr", 32'(wr_err), 0);
      wr_bit(1, 0);
      chk("t3_full_err", 32'(wr_err), 1);
      chk("t3_cnt_hold", 32'(a_cnt), 128);
      wr_eof = 1; tick(); idle();
      chk("t3_seal_rdy", 32'(a_rdy), 1);

      // T4: seal B too, write while both sealed is dropped, then drain A
      wr_bit(1,0); wr_bit(0,1);
      chk("t4_b_cnt", 32'(b_cnt), 2);
      chk("t4_wr_rdy0", 32'(wr_rdy), 0);
      wr_bit(1, 0);
      chk("t4_drop_err", 32'(wr_err), 1);
      chk("t4_cnts_hold", {a_cnt, b_cnt}, {8'd128, 8'd2});
      for (int k = 0; k < 12; k++) begin
         a_rda_en = 1; tick(); idle();
         if (k == 0) chk("t4_rda_first", 32'(a_rda), 32'b0100100100);
      end
      chk("t4_cnt8", 32'(a_cnt), 8);
      chk("t4_wr_rdy_still0", 32'(wr_rdy), 0);
      a_rdb_en = 1; tick(); idle();
      a_rdb_en = 1; tick(); idle();
      chk("t4_rdb_last", 32'(a_rdb), 32'b1001);
      chk("t4_drained", {a_cnt, 7'h0, a_rdy}, 0);
      chk("t4_drain_noerr", 32'(wr_err), 0);
      tick();
      chk("t4_wr_rdy1", 32'(wr_rdy), 1);
      wr_bit(1, 0);
      chk("t4_sel_a", {a_cnt, b_cnt}, {8'd1, 8'd2});

      // T5: simultaneous pop enables on A, read on filling B, reset mid-segment
      do_reset();
      for (int i = 0; i < 20; i++) wr_bit(logic'(i[0]), logic'(i == 19));
      chk("t5_cnt20", 32'(a_cnt), 20);
      a_rda_en = 1; a_rdb_en = 1; a_rd1_en = 1; tick(); idle();
      chk("t5_cnt10", 32'(a_cnt), 10);
      chk("t5_multi_err", 32'(wr_err), 1);
      chk("t5_rda", 32'(a_rda), 32'b1010101010);
      chk("t5_losers_hold", {a_rdb, a_rd1}, 0);
      wr_bit(1,0); wr_bit(1,0);
      chk("t5_b_fill", 32'(b_cnt), 2);
      b_rd1_en = 1; tick(); idle();
      chk("t5_b_notsealed_err", 32'(wr_err), 1);
      chk("t5_b_hold", {b_cnt, 7'h0, b_rd1}, {8'd2, 8'd0});
      do_reset();
      chk_reset("rst1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d", total);
      $fatal(1, "timeout");
   end
endmodule
